vx_csr_dispatch: RTL

Parametrised, multi-lane CSR execution unit for the SFU path that replaces the single-cycle, combinational-read CSR unit. It accepts one CSR instruction at a time from issue and decodes the address to the local CSR file or one of NUM_EXT external CSR windows; external windows use a variable-latency req/rsp handshake with a timeout. It performs CSRRW/CSRRS/CSRRC read-modify-write, unlocks the warp, and returns per-lane results to commit through a RSP_DEPTH-entry buffer.

---
 rtl/vx_csr_dispatch.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/vx_csr_dispatch.sv
// Multi-lane CSR execution unit: local CSR file RMW or external windowed CSRs, results via commit FIFO.
// Optional macro VX_CSR_DRAIN_EN: issue is held off until the warp pipeline reports empty.
module vx_csr_dispatch #(
    parameter int          NUM_LANES      = 4,
    parameter int          NUM_WARPS      = 4,
    parameter int          NUM_EXT        = 2,
    parameter logic [11:0] EXT_BASE       = 12'h7C0,
    parameter int          EXT_SPAN       = 16,
    parameter int          RSP_DEPTH      = 2,
    parameter int          TIMEOUT_CYCLES = 255,
    localparam int         WIDW           = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int         DW             = NUM_LANES * 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [WIDW-1:0]         req_wid,
    input  logic [NUM_LANES-1:0]    req_tmask,
    input  logic [31:0]             req_pc,
    input  logic [4:0]              req_rd,
    input  logic                    req_wb,
    input  logic [1:0]              req_op,
    input  logic [11:0]             req_addr,
    input  logic                    req_use_imm,
    input  logic [4:0]              req_imm,
    input  logic [DW-1:0]           req_rs1,
    input  logic                    alm_empty,
    output logic [WIDW-1:0]         alm_empty_wid,
    output logic                    loc_rd_en,
    output logic                    loc_wr_en,
    output logic [11:0]             loc_addr,
    input  logic [31:0]             loc_rd_data,
    output logic [31:0]             loc_wr_data,
    output logic [NUM_EXT-1:0]      ext_req_valid,
    input  logic [NUM_EXT-1:0]      ext_req_ready,
    output logic                    ext_req_write,
    output logic [11:0]             ext_req_addr,
    output logic [WIDW-1:0]         ext_req_wid,
    output logic [NUM_LANES-1:0]    ext_req_tmask,
    output logic [DW-1:0]           ext_req_data,
    input  logic [NUM_EXT-1:0]      ext_rsp_valid,
    input  logic [NUM_EXT*DW-1:0]   ext_rsp_data,
    output logic                    unlock_valid,
    output logic [WIDW-1:0]         unlock_wid,
    output logic                    cm_valid,
    input  logic                    cm_ready,
    output logic [WIDW-1:0]         cm_wid,
    output logic [NUM_LANES-1:0]    cm_tmask,
    output logic [31:0]             cm_pc,
    output logic [4:0]              cm_rd,
    output logic                    cm_wb,
    output logic [DW-1:0]           cm_data,
    output logic                    cm_err
);

    localparam int WIDK = (NUM_EXT > 1) ? $clog2(NUM_EXT) : 1;
    localparam int CW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int PW   = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int NW   = $clog2(RSP_DEPTH + 1);
    localparam int EW   = WIDW + NUM_LANES + 32 + 5 + 1 + 1 + DW;

    typedef enum logic [2:0] {
        S_IDLE, S_LOCAL, S_EXT_REQ, S_EXT_WAIT, S_PUSH
    } state_t;

    function automatic logic [31:0] csr_rmw(input logic [1:0] op, input logic [31:0] cur,
                                            input logic [31:0] src);
        case (op)
            2'b00:   csr_rmw = src;
            2'b01:   csr_rmw = cur | src;
            default: csr_rmw = cur & ~src;
        endcase
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        ptr_inc = (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    state_t                 state, state_nxt;
    logic [CW-1:0]          tmo_cnt;
    logic                   drain_ok;
    logic                   dec_hit;
    logic [WIDK-1:0]        dec_win;
    logic                   push, pop, can_push, rsp_hit, tmo_hit;

    logic [WIDW-1:0]        wid_p0;
    logic [NUM_LANES-1:0]   tmask_p0;
    logic [31:0]            pc_p0;
    logic [4:0]             rd_p0;
    logic                   wb_p0;
    logic [1:0]             op_p0;
    logic [11:0]            addr_p0;
    logic                   use_imm_p0;
    logic [4:0]             imm_p0;
    logic [DW-1:0]          rs1_p0;
    logic [WIDK-1:0]        win_p0;
    logic [31:0]            src_p0;

    logic [DW-1:0]          data_p1;
    logic                   err_p1;

    logic [EW-1:0]          fifo_mem [RSP_DEPTH];
    logic [PW-1:0]          wr_ptr, rd_ptr;
    logic [NW-1:0]          count;
    logic [EW-1:0]          head;

`ifdef VX_CSR_DRAIN_EN
    assign drain_ok = alm_empty;
`else
    logic drain_unused;
    assign drain_ok     = 1'b1;
    assign drain_unused = alm_empty;
`endif

    assign alm_empty_wid = req_wid;

    always_comb begin
        dec_hit = 1'b0;
        dec_win = '0;
        for (int k = 0; k < NUM_EXT; k++) begin
            if (int'(req_addr) >= int'(EXT_BASE) + k * EXT_SPAN &&
                int'(req_addr) <  int'(EXT_BASE) + (k + 1) * EXT_SPAN) begin
                dec_hit = 1'b1;
                dec_win = WIDK'(k);
            end
        end
    end

    assign src_p0   = use_imm_p0 ? {27'd0, imm_p0} : rs1_p0[31:0];
    assign rsp_hit  = ext_rsp_valid[win_p0];
    assign tmo_hit  = (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign can_push = (count != NW'(RSP_DEPTH)) || cm_ready;

    always_comb begin
        state_nxt     = state;
        req_ready     = 1'b0;
        loc_rd_en     = 1'b0;
        loc_wr_en     = 1'b0;
        loc_addr      = '0;
        loc_wr_data   = '0;
        ext_req_valid = '0;
        ext_req_write = 1'b0;
        ext_req_addr  = '0;
        ext_req_wid   = '0;
        ext_req_tmask = '0;
        ext_req_data  = '0;
        unlock_valid  = 1'b0;
        unlock_wid    = '0;
        push          = 1'b0;
        if (!reset) begin
            unique case (state)
                S_IDLE: begin
                    req_ready = drain_ok;
                    if (req_valid && drain_ok)
                        state_nxt = dec_hit ? S_EXT_REQ : S_LOCAL;
                end
                S_LOCAL: begin
                    loc_rd_en   = 1'b1;
                    loc_wr_en   = (op_p0 == 2'b00) || (src_p0 != '0);
                    loc_addr    = addr_p0;
                    loc_wr_data = csr_rmw(op_p0, loc_rd_data, src_p0);
                    state_nxt   = S_PUSH;
                end
                S_EXT_REQ: begin
                    ext_req_valid = NUM_EXT'(1) << win_p0;
                    ext_req_write = (op_p0 == 2'b00);
                    ext_req_addr  = addr_p0;
                    ext_req_wid   = wid_p0;
                    ext_req_tmask = tmask_p0;
                    ext_req_data  = use_imm_p0 ? {NUM_LANES{{27'd0, imm_p0}}} : rs1_p0;
                    if (ext_req_ready[win_p0])
                        state_nxt = S_EXT_WAIT;
                end
                S_EXT_WAIT: begin
                    if (rsp_hit || tmo_hit)
                        state_nxt = S_PUSH;
                end
                S_PUSH: begin
                    if (can_push) begin
                        push         = 1'b1;
                        unlock_valid = 1'b1;
                        unlock_wid   = wid_p0;
                        state_nxt    = S_IDLE;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            tmo_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_EXT_REQ)
                tmo_cnt <= '0;
            else if (state == S_EXT_WAIT)
                tmo_cnt <= tmo_cnt + CW'(1);
        end
    end

    // Stage p0: instruction latched at issue handshake
    always_ff @(posedge clk) begin
        if (state == S_IDLE && req_valid && req_ready) begin
            wid_p0     <= req_wid;
            tmask_p0   <= req_tmask;
            pc_p0      <= req_pc;
            rd_p0      <= req_rd;
            wb_p0      <= req_wb;
            op_p0      <= req_op;
            addr_p0    <= req_addr;
            use_imm_p0 <= req_use_imm;
            imm_p0     <= req_imm;
            rs1_p0     <= req_rs1;
            win_p0     <= dec_win;
        end
    end

    // Stage p1: result captured from the local read or the external response/timeout
    always_ff @(posedge clk) begin
        if (state == S_LOCAL) begin
            data_p1 <= {NUM_LANES{loc_rd_data}};
            err_p1  <= 1'b0;
        end else if (state == S_EXT_WAIT && rsp_hit) begin
            data_p1 <= ext_rsp_data[int'(win_p0) * DW +: DW];
            err_p1  <= 1'b0;
        end else if (state == S_EXT_WAIT && tmo_hit) begin
            data_p1 <= '0;
            err_p1  <= 1'b1;
        end
    end

    // Stage p2: commit FIFO, head drives cm_*
    assign pop = cm_valid && cm_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)
                count <= count + NW'(1);
            else if (!push && pop)
                count <= count - NW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= {wid_p0, tmask_p0, pc_p0, rd_p0, wb_p0, err_p1, data_p1};
    end

    assign head     = fifo_mem[rd_ptr];
    assign cm_valid = !reset && (count != '0);
    assign {cm_wid, cm_tmask, cm_pc, cm_rd, cm_wb, cm_err, cm_data} = cm_valid ? head : '0;

endmodule
